// File: rtl/mc_pkg.sv
// Shared definitions for the multicycle MIPS main control: state codes,
// opcodes and the datapath select encodings driven by the controller.
package mc_pkg;

  typedef enum logic [3:0] {
    S_RESET  = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_MEMADR = 4'd3,
    S_MEMRD  = 4'd4,
    S_MEMWB  = 4'd5,
    S_MEMWR  = 4'd6,
    S_RTEX   = 4'd7,
    S_RTWB   = 4'd8,
    S_BEQEX  = 4'd9,
    S_ADDIEX = 4'd10,
    S_ADDIWB = 4'd11,
    S_JEX    = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_REGB    = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/mc_main_control.sv
// Multicycle MIPS main control FSM: sequences fetch/decode/execute/memory/
// writeback enables from the opcode, stalling memory steps until MemReady.
module mc_main_control
  import mc_pkg::*;
#(
  parameter int USE_MEM_READY = 1,
  parameter int STATE_W       = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] Opcode,
  input  logic       MemReady,
  output logic [1:0] ALUOp,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic       PCWrite,
  output logic       Branch,
  output logic [1:0] PCSrc,
  output logic       IllegalOp
);

  localparam logic [STATE_W-1:0] ST_RESET  = STATE_W'(S_RESET);
  localparam logic [STATE_W-1:0] ST_FETCH  = STATE_W'(S_FETCH);
  localparam logic [STATE_W-1:0] ST_DECODE = STATE_W'(S_DECODE);
  localparam logic [STATE_W-1:0] ST_MEMADR = STATE_W'(S_MEMADR);
  localparam logic [STATE_W-1:0] ST_MEMRD  = STATE_W'(S_MEMRD);
  localparam logic [STATE_W-1:0] ST_MEMWB  = STATE_W'(S_MEMWB);
  localparam logic [STATE_W-1:0] ST_MEMWR  = STATE_W'(S_MEMWR);
  localparam logic [STATE_W-1:0] ST_RTEX   = STATE_W'(S_RTEX);
  localparam logic [STATE_W-1:0] ST_RTWB   = STATE_W'(S_RTWB);
  localparam logic [STATE_W-1:0] ST_BEQEX  = STATE_W'(S_BEQEX);
  localparam logic [STATE_W-1:0] ST_ADDIEX = STATE_W'(S_ADDIEX);
  localparam logic [STATE_W-1:0] ST_ADDIWB = STATE_W'(S_ADDIWB);
  localparam logic [STATE_W-1:0] ST_JEX    = STATE_W'(S_JEX);

  logic [STATE_W-1:0] state_reg;
  logic [STATE_W-1:0] state_next;
  logic               mem_ready;

  // With the handshake disabled every memory access completes in one cycle.
  assign mem_ready = (USE_MEM_READY != 0) ? MemReady : 1'b1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_reg <= ST_RESET;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = ST_FETCH;
    ALUOp      = ALUOP_ADD;
    ALUSrcA    = 1'b0;
    ALUSrcB    = SRCB_REGB;
    IorD       = 1'b0;
    MemRead    = 1'b0;
    MemWrite   = 1'b0;
    IRWrite    = 1'b0;
    RegDst     = 1'b0;
    MemtoReg   = 1'b0;
    RegWrite   = 1'b0;
    PCWrite    = 1'b0;
    Branch     = 1'b0;
    PCSrc      = PCSRC_ALU;
    IllegalOp  = 1'b0;

    case (state_reg)
      ST_RESET: state_next = ST_FETCH;
      ST_FETCH: begin
        MemRead    = 1'b1;
        ALUSrcB    = SRCB_FOUR;
        IRWrite    = mem_ready;
        PCWrite    = mem_ready;
        state_next = mem_ready ? ST_DECODE : ST_FETCH;
      end
      ST_DECODE: begin
        // Branch target is precomputed here while the opcode is decoded.
        ALUSrcB = SRCB_IMM_SH2;
        case (Opcode)
          OP_LW, OP_SW: state_next = ST_MEMADR;
          OP_RTYPE:     state_next = ST_RTEX;
          OP_BEQ:       state_next = ST_BEQEX;
          OP_ADDI:      state_next = ST_ADDIEX;
          OP_J:         state_next = ST_JEX;
          default: begin
            IllegalOp  = 1'b1;
            state_next = ST_FETCH;
          end
        endcase
      end
      ST_MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
        if (Opcode == OP_LW)      state_next = ST_MEMRD;
        else if (Opcode == OP_SW) state_next = ST_MEMWR;
        else                      state_next = ST_FETCH;
      end
      ST_MEMRD: begin
        MemRead    = 1'b1;
        IorD       = 1'b1;
        state_next = mem_ready ? ST_MEMWB : ST_MEMRD;
      end
      ST_MEMWB: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
      end
      ST_MEMWR: begin
        MemWrite   = 1'b1;
        IorD       = 1'b1;
        state_next = mem_ready ? ST_FETCH : ST_MEMWR;
      end
      ST_RTEX: begin
        ALUSrcA    = 1'b1;
        ALUOp      = ALUOP_FUNCT;
        state_next = ST_RTWB;
      end
      ST_RTWB: begin
        RegWrite = 1'b1;
        RegDst   = 1'b1;
      end
      ST_BEQEX: begin
        ALUSrcA = 1'b1;
        ALUOp   = ALUOP_SUB;
        Branch  = 1'b1;
        PCSrc   = PCSRC_ALUOUT;
      end
      ST_ADDIEX: begin
        ALUSrcA    = 1'b1;
        ALUSrcB    = SRCB_IMM;
        state_next = ST_ADDIWB;
      end
      ST_ADDIWB: RegWrite = 1'b1;
      ST_JEX: begin
        PCWrite = 1'b1;
        PCSrc   = PCSRC_JUMP;
      end
      default: state_next = ST_FETCH;
    endcase
  end

endmodule
